// File: rtl/mux4_rr_arb_if.sv
// Handshake and data bundle between four requesters, the round-robin arbiter and the consumer.
// The slave modport is the arbiter's view; the master modport is the requester/consumer view.
interface mux4_rr_arb_if #(
  parameter int N = 4
);
  logic [3:0]   req;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_c;
  logic [N-1:0] in_d;
  logic         out_ready;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         busy;

  modport master (
    output req, in_a, in_b, in_c, in_d, out_ready,
    input  gnt, sel, out_valid, out_data, busy
  );

  modport slave (
    input  req, in_a, in_b, in_c, in_d, out_ready,
    output gnt, sel, out_valid, out_data, busy
  );
endinterface

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter feeding a registered 4:1 mux with a valid/ready output stage.
// Optional burst lock (extra lock[3:0] port) is enabled by defining ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no captured word; a request is granted and captured immediately
// HOLD  | out_data holds an untransferred word; re-arbitrate on each transfer
module mux4_rr_arb #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ARB_LOCK_EN
  input  logic [3:0]    lock,
`endif
  mux4_rr_arb_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [1:0]   ptr_q;
  logic [1:0]   sel_q;
  logic [N-1:0] data_q;

  logic         any_req;
  logic         capture;
  logic [1:0]   win;
  logic [1:0]   idx;
  logic         found;
  logic [1:0]   ptr_nxt;
  logic [N-1:0] win_data;
  logic [3:0]   gnt_c;
  logic         valid_c;

  assign any_req = |bus.req;

  // Scan from ptr upwards (mod 4); the first requester found wins.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // A capture happens on any request in IDLE, or on a transfer cycle in HOLD.
  assign capture = !rst && any_req && ((state_q == IDLE) || bus.out_ready);

  always_comb begin
    case (win)
      2'd0:    win_data = bus.in_a;
      2'd1:    win_data = bus.in_b;
      2'd2:    win_data = bus.in_c;
      default: win_data = bus.in_d;
    endcase
  end

`ifdef ARB_LOCK_EN
  // A locked winner parks the pointer on itself so it stays first in line.
  assign ptr_nxt = lock[win] ? win : win + 2'd1;
`else
  assign ptr_nxt = win + 2'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = HOLD;
      HOLD: if (bus.out_ready && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_c   = 4'b0000;
    valid_c = (state_q == HOLD);
    if (capture) begin
      gnt_c = 4'b0001 << win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= 2'd0;
      sel_q  <= 2'd0;
      data_q <= '0;
    end else if (capture) begin
      ptr_q  <= ptr_nxt;
      sel_q  <= win;
      data_q <= win_data;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_c;
  assign bus.busy      = valid_c;
  assign bus.out_data  = data_q;

endmodule
